mem_port_arbiter: RTL and testbench

Shares the core's single external memory port between the instruction-fetch requester (IF stage) and the data-memory requester (MEM-stage cache refill/write-through). It sits between the two requesters and the top-level mem_addr/mem_data_in/mem_write_en/mem_data_out pins. It sequences each access over a fixed memory latency and returns a one-cycle done pulse with captured read data. Data requests have priority, with a starvation guard for fetch.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_latency_counter.sv | 38 +++
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the external memory-port arbiter: FSM states, grant owner
// and the four-byte word carried on every data path.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  typedef logic [7:0] byte_word_t [0:3];

  localparam byte_word_t ZERO_WORD = '{default: 8'h00};

endpackage

// File: rtl/mem_arb_latency_counter.sv
// Counts the cycles an access has occupied the memory port; last flags the
// final cycle of the access.
module mem_arb_latency_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clear,
  input  logic enable,
  output logic last
);

  localparam int unsigned CW = $clog2(MEM_LATENCY + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == CW'(MEM_LATENCY - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single external memory port between instruction fetch and data
// requesters; data wins, with a starvation guard that eventually forces fetch.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LATENCY  = 4,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output byte_word_t  if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  byte_word_t  dm_wdata,
  output logic        dm_done,
  output byte_word_t  dm_rdata,
  output logic [31:0] mem_addr,
  output byte_word_t  mem_data_in,
  output logic        mem_write_en,
  input  byte_word_t  mem_data_out,
  output logic        busy,
  output logic        owner
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [31:0]   addr_q, addr_d;
  byte_word_t    wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          wen_q, wen_d;
  logic          if_done_q, if_done_d;
  logic          dm_done_q, dm_done_d;
  logic          busy_q, busy_d;
  byte_word_t    if_rdata_q, if_rdata_d;
  byte_word_t    dm_rdata_q, dm_rdata_d;
  logic [SW-1:0] starve_q, starve_d;

  logic start;
  logic cnt_last;
  logic grant_dm;

  assign start = (state_q == IDLE) && (if_req || dm_req);

  mem_arb_latency_counter #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_latency (
    .clk   (clk),
    .rst_b (rst_b),
    .clear (start),
    .enable(state_q == ACCESS),
    .last  (cnt_last)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    wen_d      = 1'b0;
    if_done_d  = 1'b0;
    dm_done_d  = 1'b0;
    busy_d     = busy_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    starve_d   = starve_q;
    grant_dm   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          grant_dm = dm_req && !(if_req && (starve_q == STARVE_MAX));
          owner_d  = grant_dm ? OWN_DM : OWN_IF;
          addr_d   = grant_dm ? dm_addr : if_addr;
          wdata_d  = grant_dm ? dm_wdata : ZERO_WORD;
          we_d     = grant_dm && dm_we;
          wen_d    = grant_dm && dm_we;
          busy_d   = 1'b1;
          state_d  = ACCESS;
          // Only a data grant that bypasses a waiting fetch counts toward starvation.
          if (grant_dm && if_req) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1);
          end else begin
            starve_d = '0;
          end
        end
      end
      ACCESS: begin
        if (cnt_last) begin
          state_d = RESP;
          if (owner_q == OWN_DM) begin
            dm_done_d = 1'b1;
            if (!we_q) begin
              dm_rdata_d = mem_data_out;
            end
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_data_out;
          end
        end
      end
      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      addr_q     <= '0;
      wdata_q    <= ZERO_WORD;
      we_q       <= 1'b0;
      wen_q      <= 1'b0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
      busy_q     <= 1'b0;
      if_rdata_q <= ZERO_WORD;
      dm_rdata_q <= ZERO_WORD;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      wen_q      <= wen_d;
      if_done_q  <= if_done_d;
      dm_done_q  <= dm_done_d;
      busy_q     <= busy_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      starve_q   <= starve_d;
    end
  end

  assign if_done      = if_done_q;
  assign dm_done      = dm_done_q;
  assign if_rdata     = if_rdata_q;
  assign dm_rdata     = dm_rdata_q;
  assign mem_addr     = addr_q;
  assign mem_data_in  = wdata_q;
  assign mem_write_en = wen_q;
  assign busy         = busy_q;
  assign owner        = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// checked against a transaction-level model of the shared port.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned L     = 4;
  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, mem_addr;
  byte_word_t  dm_wdata, if_rdata, dm_rdata, mem_data_in, mem_data_out;
  logic        if_done, dm_done, mem_write_en, busy, owner;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .MEM_LATENCY (L),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_done     (if_done),
    .if_rdata    (if_rdata),
    .dm_req      (dm_req),
    .dm_we       (dm_we),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_done     (dm_done),
    .dm_rdata    (dm_rdata),
    .mem_addr    (mem_addr),
    .mem_data_in (mem_data_in),
    .mem_write_en(mem_write_en),
    .mem_data_out(mem_data_out),
    .busy        (busy),
    .owner       (owner)
  );

  function automatic logic [31:0] pack(input byte_word_t b);
    return {b[0], b[1], b[2], b[3]};
  endfunction

  function automatic byte_word_t unpack(input logic [31:0] w);
    byte_word_t b;
    for (int i = 0; i < 4; i++) b[i] = w[31-8*i -: 8];
    return b;
  endfunction

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment memory: data is only valid in the cycle the model expects it
  // to be sampled, so early or late capture returns a garbage pattern.
  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  logic        seed;
  int unsigned cap_cyc = 0;

  always @(posedge clk) begin
    if (seed) begin
      for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
    end else if (mem_write_en) begin
      mem[mem_addr[9:2]] <= pack(mem_data_in);
    end
  end

  always_comb mem_data_out = unpack((cyc == cap_cyc) ? mem[mem_addr[9:2]] : 32'hE5E5_E5E5);

  bit          if_pend, dm_pend, m_dm_we;
  logic [31:0] m_if_addr, m_dm_addr, m_dm_wdata;
  int unsigned starve;
  logic [31:0] exp_if_rd, exp_dm_rd;
  int unsigned n_cmp, n_err;
  bit          obs_own[$];
  int unsigned last_done_cyc, d1;
  logic [5:0]  pat;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive();
    if_req   = if_pend;
    if_addr  = m_if_addr;
    dm_req   = dm_pend;
    dm_we    = m_dm_we;
    dm_addr  = m_dm_addr;
    dm_wdata = unpack(m_dm_wdata);
  endtask

  task automatic issue_if(input logic [31:0] a);
    if_pend   = 1'b1;
    m_if_addr = a;
    drive();
  endtask

  task automatic issue_dm(input bit we, input logic [31:0] a, input logic [31:0] wd);
    dm_pend    = 1'b1;
    m_dm_we    = we;
    m_dm_addr  = a;
    m_dm_wdata = wd;
    drive();
  endtask

  task automatic chk_idle(input string tag);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_if_done"}, if_done, 1'b0);
    chk1({tag, "_dm_done"}, dm_done, 1'b0);
  endtask

  // One arbitration point: entered and left in an IDLE cycle.
  task automatic arb_step();
    bit          wd, ewe;
    logic [31:0] ea, ewd, erd;
    int unsigned c0;
    if (!if_pend && !dm_pend) begin
      tick();
      chk_idle("quiet");
      return;
    end
    c0     = cyc;
    wd     = dm_pend && !(if_pend && starve == LIMIT);
    starve = (wd && if_pend) ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
    ea     = wd ? m_dm_addr : m_if_addr;
    ewe    = wd && m_dm_we;
    ewd    = m_dm_wdata;
    erd    = ref_mem[ea[9:2]];
    if (ewe) ref_mem[ea[9:2]] = ewd;
    cap_cyc = c0 + L;
    for (int i = 1; i <= int'(L) + 1; i++) begin
      tick();
      if (i == 1) begin
        obs_own.push_back(owner);
        if (wd) begin
          dm_addr  = $urandom;
          dm_wdata = unpack($urandom);
        end else begin
          if_addr = $urandom;
        end
      end
      if (!if_pend) if_req = 1'($urandom_range(0, 1));
      if (!dm_pend) dm_req = 1'($urandom_range(0, 1));
      chk1("busy", busy, 1'b1);
      chk1("owner", owner, wd);
      if (i <= int'(L)) begin
        chk32("mem_addr", mem_addr, ea);
        chk1("mem_write_en", mem_write_en, (i == 1) && ewe);
        if (ewe) chk32("mem_data_in", pack(mem_data_in), ewd);
        chk1("if_done_early", if_done, 1'b0);
        chk1("dm_done_early", dm_done, 1'b0);
      end else begin
        chk1("if_done", if_done, !wd);
        chk1("dm_done", dm_done, wd);
        if (if_done || dm_done) last_done_cyc = cyc;
        if (!ewe) begin
          if (wd) exp_dm_rd = erd;
          else    exp_if_rd = erd;
        end
        chk32("if_rdata", pack(if_rdata), exp_if_rd);
        chk32("dm_rdata", pack(dm_rdata), exp_dm_rd);
      end
    end
    tick();
    if (wd) dm_pend = 1'b0;
    else    if_pend = 1'b0;
    drive();
    chk_idle("after_resp");
  endtask

  function automatic logic [31:0] raddr();
    return (32'($urandom_range(0, 31)) << 2) | ($urandom_range(0, 1) != 0 ? 32'h100 : 32'h0);
  endfunction

  initial begin
    n_cmp = 0; n_err = 0; starve = 0;
    exp_if_rd = '0; exp_dm_rd = '0;
    if_pend = 1'b0; dm_pend = 1'b0; m_dm_we = 1'b0;
    m_if_addr = '0; m_dm_addr = '0; m_dm_wdata = '0;
    last_done_cyc = 0; d1 = 0;
    drive();
    for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
    ref_mem[16] = 32'h1122_3344;
    rst_b = 1'b1;
    seed  = 1'b1;
    tick();
    tick();
    seed = 1'b0;
    chk_idle("reset");
    chk1("reset_owner", owner, 1'b0);
    chk1("reset_mem_write_en", mem_write_en, 1'b0);
    chk32("reset_mem_addr", mem_addr, 32'h0);
    chk32("reset_if_rdata", pack(if_rdata), 32'h0);
    rst_b = 1'b0;
    tick();

    // Lone fetch.
    issue_if(32'h40);
    arb_step();
    chk32("t1_if_rdata", pack(if_rdata), 32'h1122_3344);

    // Data write, then read it back.
    issue_dm(1'b1, 32'h100, 32'hAABB_CCDD);
    arb_step();
    issue_dm(1'b0, 32'h100, 32'h0);
    arb_step();
    chk32("t2_readback", pack(dm_rdata), 32'hAABB_CCDD);

    // Collision: data first, fetch one port occupancy later.
    obs_own.delete();
    issue_if(32'h200);
    issue_dm(1'b0, 32'h204, 32'h0);
    arb_step();
    d1 = last_done_cyc;
    arb_step();
    chk1("t3_first_dm", obs_own[0], 1'b1);
    chk1("t3_second_if", obs_own[1], 1'b0);
    chk32("t3_done_spacing", last_done_cyc - d1, L + 2);

    // Starvation: data re-requests back-to-back while fetch waits.
    obs_own.delete();
    pat = 6'b101111;
    issue_if(32'h300);
    issue_dm(1'b0, 32'h304, 32'h0);
    for (int k = 0; k < 6; k++) begin
      arb_step();
      if (k < 4) issue_dm(1'($urandom_range(0, 1)), raddr(), $urandom);
    end
    for (int k = 0; k < 6; k++) chk1($sformatf("t4_grant%0d", k), obs_own[k], pat[k]);

    // Reset in the second access cycle of a data read.
    issue_dm(1'b0, 32'h80, 32'h0);
    tick();
    tick();
    chk1("t5_busy_before", busy, 1'b1);
    rst_b = 1'b1;
    tick();
    chk_idle("t5_reset");
    chk1("t5_owner", owner, 1'b0);
    chk1("t5_mem_write_en", mem_write_en, 1'b0);
    chk32("t5_mem_addr", mem_addr, 32'h0);
    chk32("t5_mem_data_in", pack(mem_data_in), 32'h0);
    chk32("t5_if_rdata", pack(if_rdata), 32'h0);
    chk32("t5_dm_rdata", pack(dm_rdata), 32'h0);
    rst_b = 1'b0;
    dm_pend = 1'b0;
    drive();
    starve = 0; exp_if_rd = '0; exp_dm_rd = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_idle("t5_quiet");
    end
    issue_if(32'h44);
    arb_step();

    // Random traffic.
    repeat (60) begin
      if (!if_pend && $urandom_range(0, 2) != 0) issue_if(raddr());
      if (!dm_pend && $urandom_range(0, 2) != 0) issue_dm(1'($urandom_range(0, 1)), raddr(), $urandom);
      arb_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
